div_unit: RTL and testbench



---
 rtl/div_unit.sv | 163 ++++++++++++++++
 tb/tb_div_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: one quotient bit per cycle, signed or unsigned,
// with defined results for divide-by-zero and signed overflow.
module div_unit #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_flag,
    input  logic [DATAWIDTH-1:0] dividend,
    input  logic [DATAWIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quotient,
    output logic [DATAWIDTH-1:0] remainder,
    output logic                 div_zero
);

    localparam int CNT_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATAWIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [DATAWIDTH-1:0] rem_r;
    logic [DATAWIDTH-1:0] quo_r;
    logic [DATAWIDTH-1:0] dsr_r;
    logic                 q_neg_r;
    logic                 r_neg_r;
    logic                 dz_r;

    logic                 a_neg_s;
    logic                 b_neg_s;
    logic                 div_by_zero_s;
    logic [DATAWIDTH-1:0] abs_a_s;
    logic [DATAWIDTH-1:0] abs_b_s;
    logic [DATAWIDTH:0]   shifted_s;
    logic [DATAWIDTH:0]   diff_s;

    function automatic logic [DATAWIDTH-1:0] neg_if(input logic en,
                                                    input logic [DATAWIDTH-1:0] v);
        logic [DATAWIDTH-1:0] r;
        if (en) begin
            r = ~v + DATAWIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign a_neg_s       = signed_flag & dividend[DATAWIDTH-1];
    assign b_neg_s       = signed_flag & divisor[DATAWIDTH-1];
    assign div_by_zero_s = (divisor == {DATAWIDTH{1'b0}});
    assign abs_a_s       = neg_if(a_neg_s, dividend);
    assign abs_b_s       = neg_if(b_neg_s, divisor);

    // The MSB of the (W+1)-bit difference is the borrow: set means restore.
    assign shifted_s = {rem_r, quo_r[DATAWIDTH-1]};
    assign diff_s    = shifted_s - {1'b0, dsr_r};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = div_by_zero_s ? FIX : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath: operand capture, shift/subtract iterations and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {DATAWIDTH{1'b0}};
            quo_r     <= {DATAWIDTH{1'b0}};
            dsr_r     <= {DATAWIDTH{1'b0}};
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            dz_r      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= {DATAWIDTH{1'b0}};
            remainder <= {DATAWIDTH{1'b0}};
            div_zero  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        cnt_r    <= {CNT_W{1'b0}};
                        if (div_by_zero_s) begin
                            // Zero signs so FIX passes the raw values through.
                            quo_r   <= {DATAWIDTH{1'b1}};
                            rem_r   <= dividend;
                            q_neg_r <= 1'b0;
                            r_neg_r <= 1'b0;
                            dz_r    <= 1'b1;
                        end else begin
                            quo_r   <= abs_a_s;
                            rem_r   <= {DATAWIDTH{1'b0}};
                            dsr_r   <= abs_b_s;
                            q_neg_r <= a_neg_s ^ b_neg_s;
                            r_neg_r <= a_neg_s;
                            dz_r    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    quo_r <= {quo_r[DATAWIDTH-2:0], ~diff_s[DATAWIDTH]};
                    if (diff_s[DATAWIDTH]) begin
                        rem_r <= shifted_s[DATAWIDTH-1:0];
                    end else begin
                        rem_r <= diff_s[DATAWIDTH-1:0];
                    end
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                FIX: begin
                    quotient  <= neg_if(q_neg_r, quo_r);
                    remainder <= neg_if(r_neg_r, rem_r);
                    div_zero  <= dz_r;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level reference model compared every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_flag;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    div_unit #(.DATAWIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_flag(signed_flag),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference division straight from the arithmetic definition.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        logic [31:0] qq, rr;
        logic dz;
        dz = 1'b0;
        if (b == 32'd0) begin
            qq = 32'hFFFF_FFFF;
            rr = a;
            dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            qq = q[31:0];
            rr = r[31:0];
        end else begin
            qq = a / b;
            rr = a % b;
        end
        return {dz, qq, rr};
    endfunction

    // Timing model: results appear a fixed number of cycles after acceptance.
    logic        m_busy, m_done, m_dz, p_dz;
    logic [31:0] m_q, m_r, p_q, p_r;
    int          m_cnt;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_busy <= 1'b0;
            m_q    <= 32'd0;
            m_r    <= 32'd0;
            m_dz   <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy && start) begin
            m_busy <= 1'b1;
            m_dz   <= 1'b0;
            m_cnt  <= (divisor == 32'd0) ? 1 : 33;
            {p_dz, p_q, p_r} <= ref_div(dividend, divisor, signed_flag);
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
                m_dz   <= p_dz;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("model_done", {31'd0, done}, {31'd0, m_done});
            chk("model_quotient", quotient, m_q);
            chk("model_remainder", remainder, m_r);
            chk("model_div_zero", {31'd0, div_zero}, {31'd0, m_dz});
        end
    end

    // Caller is at a negedge; returns at the negedge of the done cycle.
    task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int elat);
        int lat;
        start       = 1'b1;
        signed_flag = s;
        dividend    = a;
        divisor     = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0000;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_quotient"}, quotient, eq);
        chk({nm, "_remainder"}, remainder, er);
        chk({nm, "_div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    endtask

    initial begin
        logic [64:0] pin;
        int ndone, dcyc;

        pin = ref_div(32'd100, 32'd7, 1'b0);
        chk("pin_unsigned", pin[63:32], 32'd14);
        pin = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("pin_signed_rem", pin[31:0], 32'hFFFF_FFFF);
        pin = ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("pin_overflow", pin[63:32], 32'h8000_0000);

        rst = 1'b1;
        start = 1'b0;
        signed_flag = 1'b0;
        dividend = 32'd0;
        divisor = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_div_zero", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        do_div("unsigned", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
        @(negedge clk);
        do_div("signed", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        do_div("divzero", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        do_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
        do_div("signed_neg_divisor", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        do_div("unsigned_big", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 33);
        do_div("signed_divzero", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1);
        do_div("small_over_big", 32'd3, 32'd5, 1'b0, 32'd0, 32'd3, 1'b0, 33);

        // start while busy is ignored
        start = 1'b1;
        signed_flag = 1'b0;
        dividend = 32'd100;
        divisor = 32'd7;
        @(negedge clk);
        ndone = 0;
        dcyc = 0;
        for (int c = 1; c <= 33; c++) begin
            if (c == 10) begin
                start = 1'b1;
                dividend = 32'd9;
                divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                ndone++;
                dcyc = c;
            end
        end
        chk("busy_start_done_count", ndone, 32'd1);
        chk("busy_start_done_cycle", dcyc, 32'd33);
        chk("busy_start_quotient", quotient, 32'd14);
        chk("busy_start_remainder", remainder, 32'd2);
        do_div("start_in_done_cycle", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

        // reset mid-operation
        @(negedge clk);
        start = 1'b1;
        dividend = 32'h00EE_E001;
        divisor = 32'h0011_1F10;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_quotient", quotient, 32'd0);
        chk("midreset_remainder", remainder, 32'd0);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midreset_no_done", ndone, 32'd0);
        do_div("after_reset", 32'h00EE_E001, 32'h0011_1F10, 1'b0, 32'h0000_000D,
               32'h0010_4C31, 1'b0, 33);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
